fft_p2s_out: RTL and testbench

// - Output end of the FFT datapath, mirroring the input serial-to-parallel stage.
// - Accepts 136-bit butterfly result beats (4 complex samples), buffers one 16-point frame per bank (ping-pong).
// - Emits the frame on the 34-bit pin bus in natural frequency order, one sample per handshake.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/fft_p2s_bank.sv | 28 ++
 rtl/fft_p2s_out.sv | 164 ++++++++++++++++
 tb/tb_fft_p2s_out.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and helpers for the FFT I/O stages.
// The helpers are the output bit-reversal mapping and the divide-by-N_PT rounding scaler.
package fft_pkg;

  localparam int unsigned SW     = 17;
  localparam int unsigned N_PT   = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned BEATS  = N_PT / LANES;
  localparam int unsigned K_W    = 4;
  localparam int unsigned BEAT_W = 2;

  typedef struct packed {
    logic signed [SW-1:0] re;
    logic signed [SW-1:0] im;
  } sample_t;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } rd_state_e;

  function automatic logic [K_W-1:0] bitrev4(input logic [K_W-1:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Divide by N_PT with round-half-up, saturated back to SW bits.
  function automatic logic signed [SW-1:0] scale_div(input logic signed [SW-1:0] x);
    logic signed [SW:0] ext;
    logic signed [SW:0] sum;
    logic signed [SW:0] shr;
    ext = x;
    sum = ext + (SW+1)'(8);
    shr = sum >>> 4;
    if (shr[SW] != shr[SW-1]) begin
      return shr[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    end
    return shr[SW-1:0];
  endfunction

endpackage

// File: rtl/fft_p2s_bank.sv
// Ping-pong sample store: 2 banks x N_PT samples, one beat-wide write, one async read.
// Lanes land at their bit-reversed bin address so the read side walks k in natural order.
module fft_p2s_bank
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  logic [BEAT_W-1:0]      wr_beat,
  input  sample_t [LANES-1:0]    wr_data,
  input  logic                   rd_bank,
  input  logic [K_W-1:0]         rd_addr,
  output sample_t                rd_data
);

  sample_t mem_q [2*N_PT];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[{wr_bank, bitrev4({wr_beat, 2'(l)})}] <= wr_data[l];
      end
    end
  end

  assign rd_data = mem_q[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_p2s_out.sv
// FFT output stage: 4-sample beats in, ping-pong buffered, one sample per handshake out.
// Optional FFT_P2S_SCALE_EN divides each component by N_PT on the output register load.
module fft_p2s_out
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*2*SW-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*SW-1:0]         out_data,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    ovf_err
);

  logic [1:0]        full_q, full_d, clr;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [K_W-1:0]    rd_cnt_q, rd_cnt_d;
  rd_state_e         state_q, state_d;
  sample_t           out_q, out_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              ovf_q, ovf_d;

  logic              wr_fire, wr_last, rd_fire, load;
  logic              rd_sel_bank;
  logic [K_W-1:0]    rd_sel_addr;
  sample_t           rd_data, load_data;
  sample_t [LANES-1:0] in_lanes;

  assign in_lanes = in_data;
  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = wr_fire && (beat_cnt_q == BEAT_W'(BEATS-1));
  assign rd_fire  = valid_q && out_ready;

  fft_p2s_bank u_bank (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_bank (wr_bank_q),
    .wr_beat (beat_cnt_q),
    .wr_data (in_lanes),
    .rd_bank (rd_sel_bank),
    .rd_addr (rd_sel_addr),
    .rd_data (rd_data)
  );

`ifdef FFT_P2S_SCALE_EN
  assign load_data = {scale_div(rd_data.re), scale_div(rd_data.im)};
`else
  assign load_data = rd_data;
`endif

  // Read FSM: the read address is steered to whatever sample is loaded next.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    valid_d     = valid_q;
    load        = 1'b0;
    clr         = 2'b00;
    rd_sel_bank = rd_bank_q;
    rd_sel_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          load     = 1'b1;
          rd_cnt_d = '0;
          valid_d  = 1'b1;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (rd_fire) begin
          if (rd_cnt_q == K_W'(N_PT-1)) begin
            clr[rd_bank_q] = 1'b1;
            rd_bank_d      = !rd_bank_q;
            rd_cnt_d       = '0;
            if (full_q[!rd_bank_q]) begin
              load        = 1'b1;
              rd_sel_bank = !rd_bank_q;
            end else begin
              valid_d = 1'b0;
              state_d = StIdle;
            end
          end else begin
            load        = 1'b1;
            rd_sel_addr = rd_cnt_q + K_W'(1);
            rd_cnt_d    = rd_cnt_q + K_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write side; a frame-complete write and read on opposite banks both land here.
  always_comb begin
    full_d     = full_q & ~clr;
    wr_bank_d  = wr_bank_q;
    beat_cnt_d = beat_cnt_q;
    if (wr_fire) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        beat_cnt_d        = '0;
      end
    end
    ovf_d = ovf_q | (in_valid & ~in_ready);
  end

  always_comb begin
    out_d = out_q;
    sof_d = sof_q;
    eof_d = eof_q;
    if (load) begin
      out_d = load_data;
      sof_d = (rd_sel_addr == '0);
      eof_d = (rd_sel_addr == K_W'(N_PT-1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      beat_cnt_q <= '0;
      rd_cnt_q   <= '0;
      state_q    <= StIdle;
      out_q      <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      beat_cnt_q <= beat_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      state_q    <= state_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = out_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_fft_p2s_out.sv
// Bench for fft_p2s_out: directed scenarios with random sample data checked against a
// frame-level reference queue (bins in natural order, optional divide-by-16 rounding).
module tb_fft_p2s_out;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [135:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [33:0]  out_data;
  logic         out_sof;
  logic         out_eof;
  logic         ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q [$];   // {sof, eof, re, im}
  logic [16:0] fr_re [16];
  logic [16:0] fr_im [16];

  always #5 clk = ~clk;

  fft_p2s_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .ovf_err   (ovf_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_comp(input logic [16:0] v);
    int x;
    int r;
    x = $signed(v);
`ifdef FFT_P2S_SCALE_EN
    x = x + 8;
    r = (x >= 0) ? x / 16 : -((-x + 15) / 16);
    if (r > 65535) r = 65535;
    if (r < -65536) r = -65536;
`else
    r = x;
`endif
    return r[16:0];
  endfunction

  function automatic int bin_of(input int b, input int l);
    int idx;
    idx = 4 * b + l;
    return ((idx & 1) << 3) | ((idx & 2) << 1) | ((idx & 4) >> 1) | ((idx & 8) >> 3);
  endfunction

  function automatic logic [135:0] beat_data(input int b);
    logic [135:0] d;
    d = '0;
    for (int l = 0; l < 4; l++) d[34*l +: 34] = {fr_re[bin_of(b, l)], fr_im[bin_of(b, l)]};
    return d;
  endfunction

  task automatic make_frame(input bit ramp);
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = ramp ? 17'(k) : 17'($urandom);
      fr_im[k] = ramp ? 17'(-k) : 17'($urandom);
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < 16; k++)
      exp_q.push_back({k == 0, k == 15, ref_comp(fr_re[k]), ref_comp(fr_im[k])});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [135:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_accept", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int b = 0; b < 4; b++) begin
      send_beat(beat_data(b));
      if (b < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("valid_seen", seen, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk("drain", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_ovf_err", ovf_err, 0);
  endtask

  // Output monitor: every handshake is scored against the reference queue.
  logic        stall_prev = 1'b0;
  logic [35:0] held;
  int          run = 0;
  int          last_run = 0;

  always @(negedge clk) begin
    logic [35:0] e;
    if (rst_n !== 1'b0) begin
      stall_prev = 1'b0;
      run        = 0;
      last_run   = 0;
    end else begin
      if (out_valid) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (stall_prev) chk("hold_stable", {out_valid, out_sof, out_eof, out_data}, {1'b1, held});
      if (out_valid && out_ready) begin
        chk("sample_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[33:0]);
          chk("out_sof", out_sof, e[35]);
          chk("out_eof", out_eof, e[34]);
        end
        stall_prev = 1'b0;
      end else if (out_valid) begin
        stall_prev = 1'b1;
        held       = {out_sof, out_eof, out_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] exp7;
    logic [16:0] sc_exp [4];
`ifdef FFT_P2S_SCALE_EN
    sc_exp[0] = 17'd4096;
    sc_exp[1] = 17'h1ffff;
    sc_exp[2] = 17'd1;
    sc_exp[3] = 17'd0;
`else
    sc_exp[0] = 17'd65535;
    sc_exp[1] = 17'h1ffe8;
    sc_exp[2] = 17'd8;
    sc_exp[3] = 17'd7;
`endif
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    do_reset(2);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;

    // Single frame, ramp data, latency and 16-cycle burst
    make_frame(1'b1);
    push_frame();
    send_frame(0);
    @(negedge clk);
    chk("lat_before", out_valid, 0);
    @(negedge clk);
    chk("lat_first", out_valid, 1);
    chk("lat_first_sof", out_sof, 1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("run16", out_valid, 1);
    end
    @(negedge clk);
    chk("run16_end", out_valid, 0);
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure at k=7
    make_frame(1'b1);
    push_frame();
    send_frame(0);
    wait_valid();
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp7 = {ref_comp(17'd7), ref_comp(17'h1fff9)};
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Ping-pong full, overflow beat dropped
    out_ready = 1'b0;
    make_frame(1'b0);
    push_frame();
    send_frame(0);
    make_frame(1'b0);
    push_frame();
    send_frame(0);
    @(negedge clk);
    chk("pp_in_ready", in_ready, 0);
    chk("pp_ovf_before", ovf_err, 0);
    chk("pp_sof_held", out_sof, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("pp_run32", out_valid, 1);
    end
    @(negedge clk);
    chk("pp_run32_end", out_valid, 0);
    @(posedge clk);
    #1;
    wait_drain();
    chk("ovf_sticky", ovf_err, 1);
    do_reset(1);

    // Three back-to-back frames at one beat per 4 cycles
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      make_frame(1'b0);
      push_frame();
      send_frame(3);
      repeat (3) begin @(posedge clk); #1; end
    end
    wait_drain();
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_run48", 64'(last_run), 48);
    chk("b2b_ovf", ovf_err, 0);
    @(posedge clk);
    #1;

    // Reset while one frame streams and the next is partially written
    make_frame(1'b0);
    push_frame();
    send_frame(0);
    make_frame(1'b0);
    for (int b = 0; b < 3; b++) send_beat(beat_data(b));
    do_reset(1);
    @(negedge clk);
    chk_reset_vals();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    make_frame(1'b0);
    push_frame();
    send_frame(0);
    wait_drain();

    // Scaling corner values on bins 0..3
    out_ready = 1'b0;
    make_frame(1'b0);
    fr_re[0] = 17'd65535;
    fr_re[1] = 17'h1ffe8;
    fr_re[2] = 17'd8;
    fr_re[3] = 17'd7;
    push_frame();
    send_frame(0);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      chk("scale_re", out_data[33:17], sc_exp[i]);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    chk("final_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
